// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions used by the data memory:
// load/store funct3 encodings, the data-memory sequencer states and XLEN.
package riscv_pkg;

    localparam int XLEN = 32;

    // RV32I load/store funct3 encodings (stores use only B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Data-memory sequencer: zero the array after reset, then serve requests
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/ram_be_1r1w.sv
// DEPTH x 32 RAM with four byte-write enables and a registered read port.
// No reset on the array or the read register so the array maps onto block RAM.
module ram_be_1r1w #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Byte-masked write; read register only updates when a read is requested
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_bytelane.sv
// RV32I data memory: byte/halfword/word loads and stores over a valid/ready
// request port with a registered single-cycle response, base-address range
// check and a post-reset clear sequencer that zeroes the array.
// Handshake: a request is taken on any rising edge where req_valid and
// req_ready are both 1; exactly one response (rsp_valid=1) follows on the
// next cycle, and responses are never back-pressured.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses are
// errors; otherwise the low address bits are masked and the access proceeds.
module dmem_bytelane
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            init_done
);

    dmem_state_e     r_state;
    dmem_state_e     w_state_next;
    logic [AW-1:0]   r_clr_idx;
    logic            w_clearing;

    logic            w_accept;
    logic [XLEN-1:0] w_off;
    logic            w_oor;
    logic [AW-1:0]   w_idx;
    logic [1:0]      w_lane;
    logic [1:0]      w_eff_lane;
    logic            w_f3_ok;
    logic            w_misalign;
    logic            w_err;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep;

    logic            w_ram_we;
    logic [3:0]      w_ram_be;
    logic [AW-1:0]   w_ram_waddr;
    logic [XLEN-1:0] w_ram_wdata;
    logic            w_ram_re;
    logic [XLEN-1:0] w_ram_q;

    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic            r_ld;
    logic [2:0]      r_ld_f3;
    logic [1:0]      r_ld_lane;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_ext;

    // Sequencer state register and clear index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_clearing) begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    // Sequencer next state and status outputs
    always_comb begin
        w_state_next = r_state;
        w_clearing   = 1'b0;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearing = 1'b1;
                if (r_clr_idx == AW'(DEPTH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    assign w_accept = req_valid & req_ready;

    // Address decode relative to the base; wrap below the base lands out of range
    assign w_off  = req_addr - BASE_ADDR;
    assign w_oor  = |w_off[XLEN-1:AW+2];
    assign w_idx  = w_off[AW+1:2];
    assign w_lane = w_off[1:0];

    // Legal funct3 set: stores have no unsigned variants
    always_comb begin
        w_f3_ok = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: w_f3_ok = 1'b1;
            F3_BU, F3_HU:     w_f3_ok = ~req_we;
            default:          w_f3_ok = 1'b0;
        endcase
    end

    // Misalignment handling: trap, or mask the low bits down to natural alignment
    always_comb begin
        w_misalign = 1'b0;
        w_eff_lane = w_lane;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01) begin
            w_misalign = w_lane[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            w_misalign = (w_lane != 2'b00);
        end
`else
        if (req_funct3[1:0] == 2'b01) begin
            w_eff_lane = {w_lane[1], 1'b0};
        end else if (req_funct3[1:0] == 2'b10) begin
            w_eff_lane = 2'b00;
        end
`endif
    end

    assign w_err = w_oor | ~w_f3_ok | w_misalign;

    // Store byte enables and lane-replicated store data
    always_comb begin
        w_be        = 4'b1111;
        w_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_eff_lane;
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << w_eff_lane;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // RAM port muxing: the clear sequencer owns the write port while clearing
    assign w_ram_we    = ~rst & (w_clearing | (w_accept & req_we & ~w_err));
    assign w_ram_be    = w_clearing ? 4'b1111 : w_be;
    assign w_ram_waddr = w_clearing ? r_clr_idx : w_idx;
    assign w_ram_wdata = w_clearing ? '0 : w_wdata_rep;
    assign w_ram_re    = ~rst & w_accept & ~req_we & ~w_err;

    ram_be_1r1w #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_idx),
        .o_rdata (w_ram_q)
    );

    // Response registers: updated on acceptance, held across idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_ld        <= 1'b0;
            r_ld_f3     <= F3_W;
            r_ld_lane   <= 2'b00;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_ld        <= ~req_we & ~w_err;
            r_ld_f3     <= req_funct3;
            r_ld_lane   <= w_eff_lane;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Load alignment and sign/zero extension of the registered RAM word
    always_comb begin
        w_shifted = w_ram_q >> {r_ld_lane, 3'b000};
        w_ext     = '0;
        case (r_ld_f3)
            F3_B:    w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    w_ext = w_shifted;
            F3_BU:   w_ext = {24'd0, w_shifted[7:0]};
            F3_HU:   w_ext = {16'd0, w_shifted[15:0]};
            default: w_ext = '0;
        endcase
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_ld ? w_ext : '0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Bench for dmem_bytelane: directed byte-lane/halfword/range/funct3/misalign/
// reset cases with literal expectations, then randomized traffic, all checked
// every cycle against a byte-array memory model.
module tb_dmem_bytelane;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  dmem_bytelane #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  logic [31:0] mo_off;
  int          mo_lane;
  int          mo_idx;
  int          mo_size;
  bit          mo_bad;
  logic [31:0] mo_val;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt   = 0;
      m_valid = 1'b0;
      m_rdata = '0;
      m_err   = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (m_cnt < DEPTH) begin
      m_cnt++;
      m_valid = 1'b0;
    end else if (req_valid) begin
      m_valid = 1'b1;
      mo_off  = req_addr - BASE;
      mo_lane = int'(mo_off % 4);
      mo_idx  = int'(mo_off / 4);
      mo_bad  = (mo_off >= 32'(DEPTH * 4));
      case (req_funct3)
        3'd0, 3'd4: mo_size = 1;
        3'd1, 3'd5: mo_size = 2;
        3'd2:       mo_size = 4;
        default: begin mo_size = 4; mo_bad = 1; end
      endcase
      if (req_we && req_funct3 > 3'd2) mo_bad = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (mo_size == 2 && (mo_lane % 2) != 0) mo_bad = 1;
      if (mo_size == 4 && mo_lane != 0) mo_bad = 1;
`else
      if (mo_size == 2) mo_lane = mo_lane & 2;
      if (mo_size == 4) mo_lane = 0;
`endif
      if (mo_bad) begin
        m_err   = 1'b1;
        m_rdata = '0;
      end else if (req_we) begin
        for (int k = 0; k < mo_size; k++)
          m_mem[mo_idx][8*(mo_lane+k) +: 8] = req_wdata[8*k +: 8];
        m_err   = 1'b0;
        m_rdata = '0;
      end else begin
        mo_val = m_mem[mo_idx] >> (8 * mo_lane);
        if (mo_size == 1) begin
          mo_val = mo_val & 32'hFF;
          if (req_funct3 == 3'd0 && mo_val >= 32'h80) mo_val = mo_val - 32'h100;
        end else if (mo_size == 2) begin
          mo_val = mo_val & 32'hFFFF;
          if (req_funct3 == 3'd1 && mo_val >= 32'h8000) mo_val = mo_val - 32'h10000;
        end
        m_err   = 1'b0;
        m_rdata = mo_val;
      end
    end else begin
      m_valid = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (started) begin
      check1("req_ready", 32'(req_ready), 32'(m_cnt == DEPTH));
      check1("init_done", 32'(init_done), 32'(m_cnt == DEPTH));
      check1("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check1("rsp_rdata", rsp_rdata, m_rdata);
      check1("rsp_err",   32'(rsp_err),   32'(m_err));
    end
  end

  // Literal expectation for the response of the request just accepted
  task automatic lit(input string name, input logic [31:0] exp_rdata, input logic exp_err);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s: got valid=%b rdata=%h err=%b, required valid=1 rdata=%h err=%b",
               name, rsp_valid, rsp_rdata, rsp_err, exp_rdata, exp_err);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge right after rst drops; counts edges until ready (bounded)
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!req_ready && edges < 200);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          edges;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    started = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ready(edges);
    check1("init_cycles", 32'(edges), 32'(DEPTH));

    do_req(1'b0, 3'd2, BASE + 32'h10, '0);          lit("lw_after_clear", 32'h0, 1'b0);
    do_req(1'b1, 3'd2, BASE + 32'h8, 32'h11223344); lit("sw_ack", 32'h0, 1'b0);
    do_req(1'b1, 3'd0, BASE + 32'h9, 32'h123456AA); lit("sb_ack", 32'h0, 1'b0);
    do_req(1'b0, 3'd2, BASE + 32'h8, '0);           lit("lw_lanes", 32'h1122AA44, 1'b0);
    do_req(1'b0, 3'd0, BASE + 32'h9, '0);           lit("lb_sext", 32'hFFFFFFAA, 1'b0);
    do_req(1'b0, 3'd4, BASE + 32'h9, '0);           lit("lbu_zext", 32'h000000AA, 1'b0);
    do_req(1'b1, 3'd1, BASE + 32'hE, 32'hFFFF8001); lit("sh_ack", 32'h0, 1'b0);
    do_req(1'b0, 3'd1, BASE + 32'hE, '0);           lit("lh_b2b", 32'hFFFF8001, 1'b0);
    do_req(1'b0, 3'd5, BASE + 32'hE, '0);           lit("lhu", 32'h00008001, 1'b0);
    do_req(1'b0, 3'd2, BASE + 32'hC, '0);           lit("lw_sh_word", 32'h80010000, 1'b0);
    do_req(1'b1, 3'd2, BASE + 32'd256, 32'hCAFEF00D); lit("sw_range_err", 32'h0, 1'b1);
    do_req(1'b0, 3'd2, BASE + 32'h0, '0);           lit("range_no_alias", 32'h0, 1'b0);
    do_req(1'b0, 3'd3, BASE + 32'h8, '0);           lit("f3_011_err", 32'h0, 1'b1);
    do_req(1'b1, 3'd4, BASE + 32'h8, 32'hFFFFFFFF); lit("store_f3_100_err", 32'h0, 1'b1);
    do_req(1'b0, 3'd2, BASE + 32'h8, '0);           lit("lw_unchanged", 32'h1122AA44, 1'b0);
    do_req(1'b1, 3'd2, BASE + 32'h4, 32'h55667788); lit("sw4_ack", 32'h0, 1'b0);
    do_req(1'b0, 3'd2, BASE + 32'h6, '0);
`ifdef DMEM_MISALIGN_TRAP_EN
    lit("lw_misalign", 32'h0, 1'b1);
    do_req(1'b0, 3'd1, BASE + 32'h5, '0);           lit("lh_misalign", 32'h0, 1'b1);
`else
    lit("lw_misalign", 32'h55667788, 1'b0);
    do_req(1'b0, 3'd1, BASE + 32'h5, '0);           lit("lh_misalign", 32'h00007788, 1'b0);
`endif
    do_req(1'b0, 3'd2, BASE - 32'h4, '0);           lit("below_base_err", 32'h0, 1'b1);
    idle(2);

    // Reset colliding with an accepted store
    do_req(1'b1, 3'd2, BASE + 32'h0, 32'h12345678);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = BASE; req_wdata = 32'hDEADBEEF; rst = 1'b1;
    @(negedge clk);
    check1("rst_drop_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0; req_valid = 1'b0;
    wait_ready(edges);
    check1("reinit_cycles", 32'(edges), 32'(DEPTH));
    do_req(1'b0, 3'd2, BASE + 32'h0, '0);           lit("lw_after_rst", 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
        else f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) < 8) addr = BASE + 32'($urandom_range(0, DEPTH * 4 + 16));
        else addr = $urandom;
        do_req(1'($urandom_range(0, 1)), f3, addr, $urandom);
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
